// File: rtl/i2c_av_pkg.sv
// Shared definitions for the codec I2C arbiter: FSM state encoding,
// the default codec write address and the controller clock divider helper.
package i2c_av_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RELOAD = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h34;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned i2c_freq);
        return clk_freq / i2c_freq;
    endfunction

endpackage

// File: rtl/i2c_codec_arbiter_if.sv
// Requester handshakes and I2C_Controller bus seen by the codec arbiter.
// master = the arbiter, slave = the requesters plus the controller.
interface i2c_codec_arbiter_if;

    logic        req0;
    logic [15:0] data0;
    logic        done0;
    logic        err0;

    logic        req1;
    logic [15:0] data1;
    logic        done1;
    logic        err1;

    logic [1:0]  gnt;
    logic        busy;

    logic        i2c_ctrl_clk;
    logic        i2c_go;
    logic [23:0] i2c_data;
    logic        i2c_end;
    logic        i2c_ack;

    modport master (
        input  req0, data0, req1, data1, i2c_end, i2c_ack,
        output done0, err0, done1, err1, gnt, busy,
               i2c_ctrl_clk, i2c_go, i2c_data
    );

    modport slave (
        output req0, data0, req1, data1, i2c_end, i2c_ack,
        input  done0, err0, done1, err1, gnt, busy,
               i2c_ctrl_clk, i2c_go, i2c_data
    );

endinterface

// File: rtl/i2c_clk_tick_gen.sv
// Divider for the I2C_Controller work clock; tick marks the iCLK cycle
// right before the controller clock rises.
module i2c_clk_tick_gen #(
    parameter int unsigned DIV = 2500
) (
    input  logic iCLK,
    input  logic iRST_N,
    output logic ctrl_clk,
    output logic tick
);

    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_C = CW'(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt      <= '0;
            ctrl_clk <= 1'b0;
        end else if (cnt == DIV_C) begin
            cnt      <= '0;
            ctrl_clk <= ~ctrl_clk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The controller samples GO/DATA on its rising edge, so the FSM moves here.
    assign tick = (cnt == DIV_C) && !ctrl_clk;

endmodule

// File: rtl/i2c_codec_arbiter.sv
// Shares one audio-codec I2C_Controller between the boot loader (port 0)
// and runtime control (port 1): round-robin grant, NACK retry, timeout.
module i2c_codec_arbiter
    import i2c_av_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned I2C_FREQ      = 20000,
    parameter logic [7:0]  DEV_ADDR      = DEV_ADDR_DEFAULT,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    i2c_codec_arbiter_if.master bus
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, I2C_FREQ);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int TW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);

    arb_state_t    state;
    logic          owner;
    logic          last_served;
    logic          fail;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] tmo_cnt;

    logic          ctrl_clk;
    logic          tick;
    logic          any_req;
    logic          pick;

    i2c_clk_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .ctrl_clk(ctrl_clk),
        .tick    (tick)
    );

    assign bus.i2c_ctrl_clk = ctrl_clk;

    // On a tie the port that was not served last wins.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            pick = ~last_served;
        end else begin
            pick = bus.req1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_served  <= 1'b1;
            fail         <= 1'b0;
            retry_cnt    <= '0;
            tmo_cnt      <= '0;
            bus.i2c_go   <= 1'b0;
            bus.i2c_data <= '0;
            bus.gnt      <= 2'b00;
            bus.busy     <= 1'b0;
            bus.done0    <= 1'b0;
            bus.err0     <= 1'b0;
            bus.done1    <= 1'b0;
            bus.err1     <= 1'b0;
        end else begin
            bus.done0 <= 1'b0;
            bus.err0  <= 1'b0;
            bus.done1 <= 1'b0;
            bus.err1  <= 1'b0;

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (any_req) begin
                            owner        <= pick;
                            bus.i2c_data <= {DEV_ADDR, (pick ? bus.data1 : bus.data0)};
                            bus.i2c_go   <= 1'b1;
                            bus.gnt      <= pick ? 2'b10 : 2'b01;
                            bus.busy     <= 1'b1;
                            retry_cnt    <= '0;
                            tmo_cnt      <= '0;
                            fail         <= 1'b0;
                            state        <= WAIT;
                        end
                    end

                    // END is checked before the timeout so a late END still counts.
                    WAIT: begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (bus.i2c_end) begin
                            bus.i2c_go <= 1'b0;
                            if (!bus.i2c_ack) begin
                                fail  <= 1'b0;
                                state <= RESP;
                            end else if (retry_cnt < RETRY_MAX) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= RELOAD;
                            end else begin
                                fail  <= 1'b1;
                                state <= RESP;
                            end
                        end else if (tmo_cnt == TMO_LAST) begin
                            bus.i2c_go <= 1'b0;
                            fail       <= 1'b1;
                            state      <= RESP;
                        end
                    end

                    RELOAD: begin
                        bus.i2c_go <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= WAIT;
                    end

                    RESP: begin
                        if (owner) begin
                            bus.done1 <= 1'b1;
                            bus.err1  <= fail;
                        end else begin
                            bus.done0 <= 1'b1;
                            bus.err0  <= fail;
                        end
                        last_served <= owner;
                        bus.gnt     <= 2'b00;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    a_done_exclusive: assert property (@(posedge iCLK) disable iff (!iRST_N)
        !(bus.done0 && bus.done1));

    a_gnt_onehot0: assert property (@(posedge iCLK) disable iff (!iRST_N)
        $onehot0(bus.gnt));

    a_busy_matches_gnt: assert property (@(posedge iCLK) disable iff (!iRST_N)
        bus.busy == (bus.gnt != 2'b00));

endmodule

// File: tb/tb_i2c_codec_arbiter.sv
// Randomised scoreboard bench for i2c_codec_arbiter with a behavioural
// I2C_Controller model that ends each transfer after three controller ticks.
module tb_i2c_codec_arbiter;

    localparam int         TICK_CYCLES   = 22;
    localparam int         MAX_RETRY     = 3;
    localparam int         TIMEOUT_TICKS = 64;
    localparam int         END_TICKS     = 3;
    localparam logic [7:0] ADDR          = 8'h34;

    typedef struct {
        int          port;
        logic [23:0] word;
        int          attempts;
        logic        err;
        bit          hang;
    } exp_t;

    logic iCLK;
    logic iRST_N;

    i2c_codec_arbiter_if bus ();

    i2c_codec_arbiter #(
        .CLK_FREQ     (1000),
        .I2C_FREQ     (100),
        .DEV_ADDR     (8'h34),
        .MAX_RETRY    (3),
        .TIMEOUT_TICKS(64)
    ) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .bus   (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   model_last;
    int   nack_left [2];
    bit   hang_cfg  [2];
    int   ctl_ticks;
    int   ctl_own;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic exp_t makeExp(input int port, input logic [15:0] d,
                                     input int nacks, input bit hang);
        exp_t e;
        e.port     = port;
        e.word     = {ADDR, d};
        e.hang     = hang;
        e.attempts = hang ? 1 : ((nacks > MAX_RETRY) ? MAX_RETRY + 1 : nacks + 1);
        e.err      = hang || (nacks > MAX_RETRY);
        return e;
    endfunction

    // Controller model: counts its own clock periods while GO is high.
    initial begin
        bus.i2c_end = 1'b0;
        bus.i2c_ack = 1'b0;
        ctl_ticks   = 0;
        ctl_own     = 0;
        forever begin
            @(negedge bus.i2c_ctrl_clk or negedge iRST_N);
            if (!iRST_N || !bus.i2c_go) begin
                ctl_ticks   = 0;
                bus.i2c_end = 1'b0;
                bus.i2c_ack = 1'b0;
            end else begin
                ctl_own = bus.gnt[1] ? 1 : 0;
                ctl_ticks++;
                if (ctl_ticks == END_TICKS && !hang_cfg[ctl_own]) begin
                    bus.i2c_end = 1'b1;
                    bus.i2c_ack = (nack_left[ctl_own] > 0);
                    if (nack_left[ctl_own] > 0) nack_left[ctl_own]--;
                end
            end
        end
    end

    // Monitor: compares every GO attempt and done pulse against the queue head.
    initial begin
        bit   go_prev;
        bit   done0_prev;
        bit   done1_prev;
        int   go_hi;
        int   go_lo;
        int   attempts;
        exp_t got;
        go_prev = 0; done0_prev = 0; done1_prev = 0;
        go_hi = 0; go_lo = 0; attempts = 0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                go_prev = 0; done0_prev = 0; done1_prev = 0;
                go_hi = 0; go_lo = 0; attempts = 0;
                continue;
            end
            if (bus.busy)
                checkOutput("gnt_onehot", 32'($countones(bus.gnt)), 1);
            else
                checkOutput("gnt_idle", 32'(bus.gnt), 0);

            if (bus.i2c_go && !go_prev) begin
                checkOutput("go_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    checkOutput("i2c_data", 32'(bus.i2c_data), 32'(exp_q[0].word));
                    checkOutput("gnt_owner", 32'(bus.gnt), (exp_q[0].port == 1) ? 2 : 1);
                    if (attempts > 0) checkOutput("reload_gap", go_lo, TICK_CYCLES);
                end
                attempts++;
                go_hi = 0;
            end
            if (!bus.i2c_go && go_prev) begin
                if (exp_q.size() != 0)
                    checkOutput("go_width", go_hi,
                                (exp_q[0].hang ? TIMEOUT_TICKS : END_TICKS) * TICK_CYCLES);
                go_lo = 0;
            end
            if (bus.i2c_go) go_hi++; else go_lo++;

            if (bus.done0 || bus.done1) begin
                checkOutput("done_overlap", 32'(bus.done0 && bus.done1), 0);
                checkOutput("done_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    checkOutput("done_port", bus.done1 ? 1 : 0, got.port);
                    checkOutput("done_err", 32'(bus.done1 ? bus.err1 : bus.err0), 32'(got.err));
                    checkOutput("attempts", attempts, got.attempts);
                    checkOutput("busy_at_done", 32'(bus.busy), 0);
                end
                if (bus.done0) checkOutput("done0_single", 32'(done0_prev), 0);
                if (bus.done1) checkOutput("done1_single", 32'(done1_prev), 0);
                attempts = 0;
            end
            go_prev    = bus.i2c_go;
            done0_prev = bus.done0;
            done1_prev = bus.done1;
        end
    end

    task automatic applyStimulus(input bit r0, input bit r1,
                                 input logic [15:0] d0, input logic [15:0] d1,
                                 input int n0, input int n1,
                                 input bit h0, input bit h1,
                                 input bit dr0, input bit dr1);
        int budget = 8000;
        int first;
        nack_left[0] = n0;
        nack_left[1] = n1;
        hang_cfg[0]  = h0;
        hang_cfg[1]  = h1;
        if (r0 && r1) begin
            first = (model_last == 0) ? 1 : 0;
            exp_q.push_back(makeExp(first, first ? d1 : d0, first ? n1 : n0, first ? h1 : h0));
            exp_q.push_back(makeExp(1 - first, first ? d0 : d1, first ? n0 : n1, first ? h0 : h1));
            model_last = 1 - first;
        end else if (r0) begin
            exp_q.push_back(makeExp(0, d0, n0, h0));
            model_last = 0;
        end else if (r1) begin
            exp_q.push_back(makeExp(1, d1, n1, h1));
            model_last = 1;
        end
        @(negedge iCLK);
        bus.data0 = d0;
        bus.data1 = d1;
        bus.req0  = r0;
        bus.req1  = r1;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge iCLK);
            budget--;
            if (dr0 && bus.gnt[0]) bus.data0 = 16'($urandom);
            if (dr1 && bus.gnt[1]) bus.data1 = 16'($urandom);
            if (bus.done0 || (dr0 && bus.gnt[0])) bus.req0 = 1'b0;
            if (bus.done1 || (dr1 && bus.gnt[1])) bus.req1 = 1'b0;
        end
        checkOutput("scenario_complete", 32'(exp_q.size()), 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (exp_q.size() != 0) begin
            iRST_N = 1'b0;
            exp_q.delete();
            repeat (2) @(negedge iCLK);
            iRST_N     = 1'b1;
            model_last = 1;
        end
        repeat (2) @(negedge iCLK);
    endtask

    task automatic dropBeforeGrant();
        int budget   = 100;
        bit prev_clk = bus.i2c_ctrl_clk;
        bit saw_busy = 0;
        while (budget > 0) begin
            @(negedge iCLK);
            budget--;
            if (bus.i2c_ctrl_clk && !prev_clk) break;
            prev_clk = bus.i2c_ctrl_clk;
        end
        checkOutput("ctrl_clk_running", 32'(budget > 0), 1);
        bus.data1 = 16'hDEAD;
        bus.req1  = 1'b1;
        repeat (3) @(negedge iCLK);
        bus.req1 = 1'b0;
        repeat (60) begin
            @(negedge iCLK);
            if (bus.busy) saw_busy = 1;
        end
        checkOutput("drop_before_grant", 32'(saw_busy), 0);
    endtask

    task automatic resetMidWait();
        int budget = 200;
        nack_left[0] = 0;
        hang_cfg[0]  = 0;
        exp_q.push_back(makeExp(0, 16'h0B0B, 0, 1'b0));
        @(negedge iCLK);
        bus.data0 = 16'h0B0B;
        bus.req0  = 1'b1;
        while (!bus.i2c_go && budget > 0) begin
            @(negedge iCLK);
            budget--;
        end
        checkOutput("go_before_reset", 32'(bus.i2c_go), 1);
        repeat (30) @(negedge iCLK);
        #2 iRST_N = 1'b0;
        #1;
        checkOutput("rst_go", 32'(bus.i2c_go), 0);
        checkOutput("rst_gnt", 32'(bus.gnt), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_ctrl_clk", 32'(bus.i2c_ctrl_clk), 0);
        checkOutput("rst_done0", 32'(bus.done0), 0);
        bus.req0 = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge iCLK);
        iRST_N     = 1'b1;
        model_last = 1;
        repeat (2) @(negedge iCLK);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        model_last   = 1;
        nack_left[0] = 0;
        nack_left[1] = 0;
        hang_cfg[0]  = 0;
        hang_cfg[1]  = 0;
        iRST_N       = 1'b0;
        bus.req0     = 1'b0;
        bus.req1     = 1'b0;
        bus.data0    = '0;
        bus.data1    = '0;
        repeat (3) @(posedge iCLK);
        #1;
        checkOutput("reset_gnt", 32'(bus.gnt), 0);
        checkOutput("reset_busy", 32'(bus.busy), 0);
        checkOutput("reset_go", 32'(bus.i2c_go), 0);
        checkOutput("reset_data", 32'(bus.i2c_data), 0);
        checkOutput("reset_done0", 32'(bus.done0), 0);
        checkOutput("reset_err0", 32'(bus.err0), 0);
        checkOutput("reset_done1", 32'(bus.done1), 0);
        checkOutput("reset_err1", 32'(bus.err1), 0);
        checkOutput("reset_ctrl_clk", 32'(bus.i2c_ctrl_clk), 0);
        @(negedge iCLK);
        iRST_N = 1'b1;

        applyStimulus(1, 1, 16'h0C00, 16'h0A17, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 16'h0E42, 16'h0880, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0C00, 16'h0000, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'h1234, 16'h0000, 2, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0A5A, 16'h0000, 9, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 16'h0000, 16'h0C1F, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 16'h0000, 16'h0D33, 1, 1, 0, 0, 0, 1);
        dropBeforeGrant();

        for (int i = 0; i < 20; i++) begin
            int sel = $urandom_range(0, 2);
            applyStimulus(sel != 1, sel != 0,
                          16'($urandom), 16'($urandom),
                          $urandom_range(0, 5), $urandom_range(0, 5),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        resetMidWait();
        applyStimulus(1, 0, 16'h1E00, 16'h0000, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
